// File: rtl/reg_file_64.sv
// reg_file_64: 32 x 64-bit integer register file with a per-register
// pending-write scoreboard. Two combinational read ports, one synchronous
// write port, x0 hardwired to zero.
// Optional build macro REGFILE_BYPASS_EN: write-through forwarding of the
// in-flight write data onto matching read ports in the same cycle.
module reg_file_64 #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            busy_any
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            wr_act;
    logic            rsv_act;
    logic [XLEN-1:0] rd1_stored;
    logic [XLEN-1:0] rd2_stored;
    logic            bz1_stored;
    logic            bz2_stored;

    assign wr_act  = wr_en  && (wr_addr  != '0);
    assign rsv_act = rsv_en && (rsv_addr != '0);

    // Scoreboard next state: writeback clears, reserve sets; reserve applied
    // last so it wins when both target the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_act) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_act) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register array and scoreboard state; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_act) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    // Stored-state reads; address 0 forced to zero / not busy.
    always_comb begin
        rd1_stored = '0;
        rd2_stored = '0;
        bz1_stored = 1'b0;
        bz2_stored = 1'b0;
        if (rs1_addr != '0) begin
            rd1_stored = regs_q[rs1_addr];
            bz1_stored = busy_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rd2_stored = regs_q[rs2_addr];
            bz2_stored = busy_q[rs2_addr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward in-flight write data; the port is not busy unless the same
    // register is being re-reserved this cycle.
    always_comb begin
        rs1_data = rd1_stored;
        rs2_data = rd2_stored;
        rs1_busy = bz1_stored;
        rs2_busy = bz2_stored;
        if (wr_act && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
            if (!(rsv_en && (rsv_addr == rs1_addr))) begin
                rs1_busy = 1'b0;
            end
        end
        if (wr_act && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
            if (!(rsv_en && (rsv_addr == rs2_addr))) begin
                rs2_busy = 1'b0;
            end
        end
    end
`else
    // Reads return stored contents only.
    always_comb begin
        rs1_data = rd1_stored;
        rs2_data = rd2_stored;
        rs1_busy = bz1_stored;
        rs2_busy = bz2_stored;
    end
`endif

    assign busy_any = |busy_q;

endmodule

// File: tb/tb_reg_file_64.sv
// Scoreboard bench for reg_file_64: the stimulus process computes expected
// read-port values from an array model and queues them; the monitor pops and
// compares once per cycle, mid-way between the falling and rising edges.
module tb_reg_file_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, rsv_addr;
    logic [63:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, busy_any, wr_en, rsv_en;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        string       tag;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        b1;
        logic        b2;
        logic        ba;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [63:0] mem [32];
    logic        bsy [32];

    always #5 clk = ~clk;

    reg_file_64 #(.XLEN(64), .NREG(32), .AW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_any (busy_any)
    );

    function automatic void chk64(string tag, string what, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", tag, what, act, req);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i] = 64'h0;
            bsy[i] = 1'b0;
        end
    endfunction

    // Expected read of one port given the current model and this cycle's write.
    function automatic void model_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                       input logic [63:0] wd, input logic re, input logic [4:0] ra,
                                       output logic [63:0] d, output logic b);
        d = (a == 0) ? 64'h0 : mem[a];
        b = (a == 0) ? 1'b0 : bsy[a];
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 0 && wa == a) begin
            d = wd;
            if (!(re && ra == a)) b = 1'b0;
        end
`endif
    endfunction

    task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                        input logic we, input logic [4:0] wa, input logic [63:0] wd,
                        input logic re, input logic [4:0] ra, input string tag);
        exp_t e;
        logic any;
        @(negedge clk);
        rst_n = rst; rs1_addr = a1; rs2_addr = a2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra;
        e.tag = tag;
        if (!rst) begin
            model_clear();
            e.d1 = 64'h0; e.d2 = 64'h0; e.b1 = 1'b0; e.b2 = 1'b0; e.ba = 1'b0;
        end else begin
            model_read(a1, we, wa, wd, re, ra, e.d1, e.b1);
            model_read(a2, we, wa, wd, re, ra, e.d2, e.b2);
            any = 1'b0;
            for (int i = 1; i < 32; i++) any |= bsy[i];
            e.ba = any;
        end
        exp_q.push_back(e);
        // State change at the coming rising edge
        if (rst) begin
            if (we && wa != 0) begin
                mem[wa] = wd;
                bsy[wa] = 1'b0;
            end
            if (re && ra != 0) bsy[ra] = 1'b1;
        end
    endtask

    // Monitor: one comparison set per cycle, sampled between edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk64(e.tag, "rs1_data", rs1_data, e.d1);
                chk64(e.tag, "rs2_data", rs2_data, e.d2);
                chk64(e.tag, "rs1_busy", {63'h0, rs1_busy}, {63'h0, e.b1});
                chk64(e.tag, "rs2_busy", {63'h0, rs2_busy}, {63'h0, e.b2});
                chk64(e.tag, "busy_any", {63'h0, busy_any}, {63'h0, e.ba});
            end
        end
    end

    initial begin
        logic [4:0] a1, a2, wa, ra;
        rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
        model_clear();

        // Reset held: outputs zero while dirty inputs are presented
        step(1'b0, 5'd5, 5'd6, 1'b1, 5'd5, 64'hDEAD, 1'b1, 5'd6, "in_reset");
        step(1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "in_reset2");

        // Every address reads zero after reset
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            step(1'b1, a1, a2, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "post_reset");
        end

        // Basic writes
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, "wr_x5");
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 5'd0, "wr_x6");
        step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "rd_x5_x6");

        // x0 write ignored
        step(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 64'h1, 1'b0, 5'd0, "wr_x0");
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, "rsv_x0");
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "rd_x0");

        // Reserve then writeback
        step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd7, "rsv_x7");
        step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 64'h1, 1'b0, 5'd0, "wb_x7");
        step(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "rd_x7");

        // Same-cycle read/write of x9
        step(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 64'h1234, 1'b0, 5'd0, "rw_x9");
        step(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "rd_x9");

        // Idempotent reserve, and plain write to non-busy register
        step(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd8, "rsv_x8");
        step(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd8, "rsv_x8_again");
        step(1'b1, 5'd8, 5'd4, 1'b1, 5'd4, 64'h44, 1'b0, 5'd0, "wr_x4");
        step(1'b1, 5'd8, 5'd4, 1'b1, 5'd8, 64'h88, 1'b0, 5'd0, "wb_x8");

        // Write and reserve x3 together: reserve wins; then async reset
        step(1'b1, 5'd3, 5'd0, 1'b1, 5'd3, 64'hDB6D_B6DB_6DB6_DB6D, 1'b1, 5'd3, "wr_rsv_x3");
        step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "rd_x3");
        step(1'b0, 5'd3, 5'd5, 1'b1, 5'd3, 64'h1111, 1'b0, 5'd0, "async_rst");
        step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, "after_rst");

        // Randomised traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            a1 = 5'($urandom_range(0, 7));
            a2 = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 59) != 0), a1, a2, ($urandom_range(0, 1) == 1), wa,
                 {$urandom, $urandom}, ($urandom_range(0, 2) == 0), ra, "random");
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
